// File: rtl/imem_access_ctrl_if.sv
// Bundles the fetch, loader, clear and memory-side signals of imem_access_ctrl.
// slave is the controller's view; master is the view of the requesters plus the imem array.
interface imem_access_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              clear_req;
  logic              busy;
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_gnt;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_instr;
  logic              fetch_err;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  clear_req, fetch_req, fetch_addr, ld_valid, ld_addr, ld_data, mem_rdata,
    output busy, fetch_gnt, fetch_valid, fetch_instr, fetch_err, ld_ready,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output clear_req, fetch_req, fetch_addr, ld_valid, ld_addr, ld_data, mem_rdata,
    input  busy, fetch_gnt, fetch_valid, fetch_instr, fetch_err, ld_ready,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_access_ctrl.sv
// Arbitrates the single-port instruction memory between the program loader and fetch,
// and owns the zero-fill sweep run after reset and on clear_req.
module imem_access_ctrl #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int LOAD_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  imem_access_ctrl_if.slave bus
);
  localparam int BW = $clog2(LOAD_BURST + 1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_SERVE = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              fetch_err_q, fetch_err_d;
  logic [DATA_W-1:0] instr_hold_q, instr_hold_d;

  logic              busy, fetch_gnt, ld_ready;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  logic              fetch_legal, burst_at_max, rd_live;
  logic [ADDR_W-1:0] fetch_word;

  assign fetch_word   = bus.fetch_addr[ADDR_W+1:2];
  assign fetch_legal  = (bus.fetch_addr[1:0] == 2'b00) && (bus.fetch_addr[31:ADDR_W+2] == '0);
  assign burst_at_max = (burst_cnt_q == BW'(LOAD_BURST));
  assign rd_live      = fetch_valid_q && !fetch_err_q;

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    busy        = 1'b0;
    fetch_gnt   = 1'b0;
    ld_ready    = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (state_q)
      ST_CLEAR: begin
        busy        = 1'b1;
        mem_en      = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = clr_ptr_q;
        clr_ptr_d   = clr_ptr_q + 1'b1;
        burst_cnt_d = '0;
        if (clr_ptr_q == '1) state_d = ST_SERVE;
      end
      default: begin
        if (bus.clear_req) begin
          state_d     = ST_CLEAR;
          clr_ptr_d   = '0;
          burst_cnt_d = '0;
        end else if (bus.fetch_req && (!bus.ld_valid || burst_at_max)) begin
          fetch_gnt   = 1'b1;
          burst_cnt_d = '0;
          if (fetch_legal) begin
            mem_en   = 1'b1;
            mem_addr = fetch_word;
          end
        end else if (bus.ld_valid) begin
          ld_ready  = 1'b1;
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = bus.ld_addr;
          mem_wdata = bus.ld_data;
          // Count only loader grants that made a waiting fetch wait longer.
          if (!bus.fetch_req)  burst_cnt_d = '0;
          else if (!burst_at_max) burst_cnt_d = burst_cnt_q + 1'b1;
        end else begin
          burst_cnt_d = '0;
        end
      end
    endcase
    // Outputs show reset values while reset is held, hiding any in-flight read return.
    if (reset) begin
      busy      = 1'b1;
      fetch_gnt = 1'b0;
      ld_ready  = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
    end
  end

  // The read word arrives combinationally in the valid cycle; the hold register keeps it afterwards.
  always_comb begin
    fetch_valid_d = fetch_gnt;
    fetch_err_d   = fetch_gnt ? !fetch_legal : fetch_err_q;
    instr_hold_d  = instr_hold_q;
    if (fetch_gnt && !fetch_legal) instr_hold_d = '0;
    else if (rd_live)              instr_hold_d = bus.mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_CLEAR;
      clr_ptr_q     <= '0;
      burst_cnt_q   <= '0;
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      instr_hold_q  <= '0;
    end else begin
      state_q       <= state_d;
      clr_ptr_q     <= clr_ptr_d;
      burst_cnt_q   <= burst_cnt_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_err_q   <= fetch_err_d;
      instr_hold_q  <= instr_hold_d;
    end
  end

  assign bus.busy        = busy;
  assign bus.fetch_gnt   = fetch_gnt;
  assign bus.ld_ready    = ld_ready;
  assign bus.mem_en      = mem_en;
  assign bus.mem_we      = mem_we;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;
  assign bus.fetch_valid = fetch_valid_q && !reset;
  assign bus.fetch_err   = fetch_err_q && !reset;
  assign bus.fetch_instr = reset ? '0 : (rd_live ? bus.mem_rdata : instr_hold_q);
endmodule

// File: tb/tb_imem_access_ctrl.sv
// Bench for imem_access_ctrl: directed steps then random traffic, checked against
// a word-array reference model of the arbitration and fetch rules.
module tb_imem_access_ctrl;
  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 32;
  localparam int LOAD_BURST = 4;
  localparam int DEPTH      = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  imem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOAD_BURST(LOAD_BURST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory the controller drives.
  logic [31:0] mem_arr [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem_arr[bus.mem_addr];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  int          clear_left, clear_idx, ld_run;
  bit          pend_v, pend_e, last_e;
  logic [31:0] pend_i, last_i;

  logic [31:0] obs_gnt, obs_ldr, obs_en, obs_we, obs_addr, obs_wd;
  logic [31:0] obs_fv, obs_fi, obs_fe, obs_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit rst, input bit cr, input bit fr, input logic [31:0] fa,
                     input bit lv, input logic [4:0] la, input logic [31:0] ld);
    bit          e_gnt, e_ldr, e_en, e_we, e_busy, fv, fe;
    logic [31:0] e_addr, e_wd, fi;
    reset         = rst;
    bus.clear_req = cr;
    bus.fetch_req = fr;
    bus.fetch_addr = fa;
    bus.ld_valid  = lv;
    bus.ld_addr   = la;
    bus.ld_data   = ld;
    @(negedge clk);
    obs_gnt  = 32'(bus.fetch_gnt);
    obs_ldr  = 32'(bus.ld_ready);
    obs_en   = 32'(bus.mem_en);
    obs_we   = 32'(bus.mem_we);
    obs_addr = 32'(bus.mem_addr);
    obs_wd   = bus.mem_wdata;
    obs_fv   = 32'(bus.fetch_valid);
    obs_fi   = bus.fetch_instr;
    obs_fe   = 32'(bus.fetch_err);
    obs_busy = 32'(bus.busy);

    if (rst) begin
      fv = 1'b0; fi = '0; fe = 1'b0;
    end else begin
      fv = pend_v;
      fi = pend_v ? pend_i : last_i;
      fe = pend_v ? pend_e : last_e;
      if (pend_v) begin last_i = pend_i; last_e = pend_e; end
    end
    chk("fetch_valid", obs_fv, 32'(fv));
    chk("fetch_instr", obs_fi, fi);
    chk("fetch_err", obs_fe, 32'(fe));

    e_gnt = 1'b0; e_ldr = 1'b0; e_en = 1'b0; e_we = 1'b0; e_busy = 1'b0;
    e_addr = '0; e_wd = '0; pend_v = 1'b0;
    if (rst) begin
      e_busy = 1'b1; clear_left = DEPTH; clear_idx = 0; ld_run = 0;
      last_i = '0; last_e = 1'b0;
    end else if (clear_left > 0) begin
      e_busy = 1'b1; e_en = 1'b1; e_we = 1'b1; e_addr = 32'(clear_idx);
      ref_mem[clear_idx] = '0;
      clear_idx++; clear_left--; ld_run = 0;
    end else if (cr) begin
      clear_left = DEPTH; clear_idx = 0; ld_run = 0;
    end else if (fr && (!lv || ld_run == LOAD_BURST)) begin
      e_gnt = 1'b1; ld_run = 0; pend_v = 1'b1;
      if ((fa % 4 == 0) && (fa < DEPTH * 4)) begin
        e_en = 1'b1; e_addr = fa / 4; pend_i = ref_mem[fa / 4]; pend_e = 1'b0;
      end else begin
        pend_i = '0; pend_e = 1'b1;
      end
    end else if (lv) begin
      e_ldr = 1'b1; e_en = 1'b1; e_we = 1'b1; e_addr = 32'(la); e_wd = ld;
      ref_mem[la] = ld;
      ld_run = fr ? ((ld_run < LOAD_BURST) ? ld_run + 1 : ld_run) : 0;
    end else begin
      ld_run = 0;
    end
    chk("busy", obs_busy, 32'(e_busy));
    chk("fetch_gnt", obs_gnt, 32'(e_gnt));
    chk("ld_ready", obs_ldr, 32'(e_ldr));
    chk("mem_en", obs_en, 32'(e_en));
    if (e_en) begin
      chk("mem_we", obs_we, 32'(e_we));
      chk("mem_addr", obs_addr, e_addr);
      if (e_we) chk("mem_wdata", obs_wd, e_wd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
  endtask
  task automatic fetch(input logic [31:0] a);
    cyc(1'b0, 1'b0, 1'b1, a, 1'b0, '0, '0);
  endtask
  task automatic load(input logic [4:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, a, d);
  endtask

  initial begin
    logic [31:0] bad [2];
    logic [14:0] pat;
    int          nb;
    bit          rfr;
    logic [31:0] rfa;
    clear_left = 0; clear_idx = 0; ld_run = 0;
    pend_v = 1'b0; pend_e = 1'b0; pend_i = '0; last_i = '0; last_e = 1'b0;

    // Reset, then the power-up sweep with both requesters and clear_req pushing.
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    chk("rst_busy", obs_busy, 32'd1);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    nb = 0;
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, i == 10, 1'b1, 32'h0C, 1'b1, 5'(i), $urandom);
      nb += int'(obs_busy);
      chk("sweep_addr", obs_addr, 32'(i));
    end
    chk("sweep_busy_cycles", 32'(nb), 32'd32);
    idle();
    chk("sweep_done_busy", obs_busy, 32'd0);

    // Load then fetch, including a fetch right after the write.
    load(5'd3, 32'h00500093);
    chk("t2_ld_ready", obs_ldr, 32'd1);
    fetch(32'h0C);
    chk("t2_gnt", obs_gnt, 32'd1);
    idle();
    chk("t2_valid", obs_fv, 32'd1);
    chk("t2_instr", obs_fi, 32'h00500093);
    chk("t2_err", obs_fe, 32'd0);
    load(5'd7, 32'hDEADBEEF);
    fetch(32'h1C);
    idle();
    chk("t2_wr_then_rd", obs_fi, 32'hDEADBEEF);

    // Misaligned and out-of-range PCs.
    bad[0] = 32'h06;
    bad[1] = 32'h80;
    for (int k = 0; k < 2; k++) begin
      fetch(bad[k]);
      chk("t3_gnt", obs_gnt, 32'd1);
      chk("t3_no_mem", obs_en, 32'd0);
      idle();
      chk("t3_valid", obs_fv, 32'd1);
      chk("t3_err", obs_fe, 32'd1);
      chk("t3_instr", obs_fi, 32'd0);
    end
    idle();
    chk("t3_err_hold", obs_fe, 32'd1);

    // Loader and fetch contending every cycle.
    pat = '0;
    for (int i = 0; i < 15; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 5'(8 + i % 4), $urandom);
      pat[i] = obs_gnt[0];
    end
    chk("t4_pattern", {17'b0, pat}, 32'h4210);
    idle();

    // clear_req in the middle of a loader burst.
    load(5'd3, 32'h00500093);
    load(5'd4, $urandom);
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b1, 5'd5, $urandom);
    chk("t5_ld_blocked", obs_ldr, 32'd0);
    nb = 0;
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      nb += int'(obs_busy);
    end
    chk("t5_busy_cycles", 32'(nb), 32'd32);
    fetch(32'h0C);
    chk("t5_busy_done", obs_busy, 32'd0);
    idle();
    chk("t5_valid", obs_fv, 32'd1);
    chk("t5_cleared", obs_fi, 32'd0);

    // Reset right after a fetch grant.
    load(5'd2, 32'h12345678);
    fetch(32'h08);
    chk("t6_gnt", obs_gnt, 32'd1);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    chk("t6_no_valid", obs_fv, 32'd0);
    chk("t6_instr", obs_fi, 32'd0);
    chk("t6_busy", obs_busy, 32'd1);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    idle();
    chk("t6_restart_addr", obs_addr, 32'd0);
    chk("t6_restart_fv", obs_fv, 32'd0);
    for (int i = 1; i < DEPTH; i++) idle();

    // Random traffic; a fetch request stays up with the same PC until granted.
    rfr = 1'b0;
    rfa = '0;
    for (int i = 0; i < 400; i++) begin
      if (!rfr) begin
        rfr = ($urandom % 3) != 0;
        case ($urandom % 4)
          0, 1:    rfa = 32'(($urandom % DEPTH) * 4);
          2:       rfa = 32'(($urandom % DEPTH) * 4 + 1 + $urandom % 3);
          default: rfa = $urandom;
        endcase
      end
      cyc(1'b0, 1'b0, rfr, rfa, 1'($urandom % 2), 5'($urandom), $urandom);
      if (obs_gnt[0]) rfr = 1'b0;
    end
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
